// File: rtl/hazard_ctrl_ml.sv
// Load-use hazard controller for the in-order RISC-V pipeline (ID stage).
// Decodes operand usage from the IF/ID instruction, detects load-use
// hazards against ID/EX, and holds the front end for LOAD_LAT cycles.
// A taken branch squashes IF/ID, and data-memory backpressure freezes
// the whole pipe.
module hazard_ctrl_ml #(
    parameter int XLEN     = 32,
    parameter int RA_W     = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   id_instr,
    input  logic              id_valid,
    input  logic [RA_W-1:0]   ex_rd,
    input  logic              ex_memread,
    input  logic              ex_regwrite,
    input  logic              branch_taken,
    input  logic              mem_busy,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_bubble,
    output logic              if_id_flush,
    output logic              stall_active,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Remaining HOLD cycles after the first (combinational) bubble.
    localparam logic [3:0] REM_INIT = 4'(LOAD_LAT - 1);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t          state, state_next;
    logic [3:0]      rem, rem_next;
    logic            count_en;

    logic [6:0]      opcode;
    logic [RA_W-1:0] rs1, rs2;
    logic            uses_rs1, uses_rs2;
    logic            hit_rs1, hit_rs2;
    logic            luh;
    logic            unused_instr_bits;

    assign opcode = id_instr[6:0];
    assign rs1    = RA_W'(id_instr[19:15]);
    assign rs2    = RA_W'(id_instr[24:20]);

    // Fields outside opcode/rs1/rs2 play no part in hazard detection.
    assign unused_instr_bits = ^{id_instr[XLEN-1:25], id_instr[14:7]};

    // Operand usage by opcode; a zero register is never a real dependency.
    always_comb begin
        uses_rs1 = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
        uses_rs2 = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
        hit_rs1  = uses_rs1 && (rs1 != '0) && (rs1 == ex_rd);
        hit_rs2  = uses_rs2 && (rs2 != '0) && (rs2 == ex_rd);
        luh      = id_valid && ex_memread && ex_regwrite && (ex_rd != '0)
                   && (hit_rs1 || hit_rs2);
    end

    // State, remaining-cycle counter and stall counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rem         <= '0;
            stall_count <= '0;
        end else begin
            state <= state_next;
            rem   <= rem_next;
            if (count_en && (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + CNT_W'(1);
        end
    end

    // Prioritised output/next-state: freeze, then flush, then stall.
    always_comb begin
        state_next   = state;
        rem_next     = rem;
        count_en     = 1'b0;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;

        if (mem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_next   = IDLE;
            rem_next     = '0;
        end else if (state == HOLD) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            count_en     = 1'b1;
            if (rem == 4'd1) begin
                state_next = IDLE;
                rem_next   = '0;
            end else begin
                rem_next = rem - 4'd1;
            end
        end else if (luh) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            count_en     = 1'b1;
            if (LOAD_LAT > 1) begin
                state_next = HOLD;
                rem_next   = REM_INIT;
            end
        end
    end

    assign stall_active = (state == HOLD);

endmodule
